// File: rtl/rs_entry_8bit_pkg.sv
// Shared widths and FSM encoding for the single reservation-station entry.
package rs_entry_8bit_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_WAIT  = 2'b01,
        ST_READY = 2'b10
    } rs_state_e;

endpackage

// File: rtl/rs_entry_8bit_if.sv
// Dispatch / CDB / issue signal bundle for the reservation-station entry.
interface rs_entry_8bit_if;
    import rs_entry_8bit_pkg::*;

    logic              flush;
    logic              alloc_valid;
    logic              alloc_ready;
    logic              alloc_a_rdy;
    logic [TAG_W-1:0]  alloc_a_tag;
    logic [DATA_W-1:0] alloc_a_val;
    logic              alloc_b_rdy;
    logic [TAG_W-1:0]  alloc_b_tag;
    logic [DATA_W-1:0] alloc_b_val;
    logic              alloc_use_imm;
    logic [DATA_W-1:0] alloc_imm;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              issue_valid;
    logic              issue_ready;
    logic [DATA_W-1:0] issue_a;
    logic [DATA_W-1:0] issue_b;
    logic [DATA_W-1:0] issue_imm;
    logic              issue_use_imm;

    modport slave (
        input  flush, alloc_valid, alloc_a_rdy, alloc_a_tag, alloc_a_val,
               alloc_b_rdy, alloc_b_tag, alloc_b_val, alloc_use_imm, alloc_imm,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output alloc_ready, issue_valid, issue_a, issue_b, issue_imm, issue_use_imm
    );

    modport master (
        output flush, alloc_valid, alloc_a_rdy, alloc_a_tag, alloc_a_val,
               alloc_b_rdy, alloc_b_tag, alloc_b_val, alloc_use_imm, alloc_imm,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  alloc_ready, issue_valid, issue_a, issue_b, issue_imm, issue_use_imm
    );

endinterface

// File: rtl/rs_entry_8bit_operand_slot.sv
// One source-operand slot: holds value/tag/ready, snoops the CDB for its producer tag.
module operand_slot_8bit
    import rs_entry_8bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              alloc_rdy,
    input  logic [TAG_W-1:0]  alloc_tag,
    input  logic [DATA_W-1:0] alloc_val,
    input  logic              watch,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic [DATA_W-1:0] val,
    output logic              rdy_next
);

    logic [DATA_W-1:0] val_q, val_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              rdy_q, rdy_d;
    logic              fwd_hit;
    logic              cdb_hit;

    // Load at allocation (with same-cycle forwarding) or capture a matching broadcast.
    always_comb begin
        val_d   = val_q;
        tag_d   = tag_q;
        rdy_d   = rdy_q;
        fwd_hit = cdb_valid && (cdb_tag == alloc_tag);
        cdb_hit = cdb_valid && (cdb_tag == tag_q);
        if (load) begin
            tag_d = alloc_tag;
            if (alloc_rdy) begin
                val_d = alloc_val;
                rdy_d = 1'b1;
            end else if (fwd_hit) begin
                val_d = cdb_data;
                rdy_d = 1'b1;
            end else begin
                val_d = alloc_val;
                rdy_d = 1'b0;
            end
        end else if (watch && !rdy_q && cdb_hit) begin
            val_d = cdb_data;
            rdy_d = 1'b1;
        end else begin
            rdy_d = rdy_q;
        end
    end

    // Slot storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q <= {DATA_W{1'b0}};
            tag_q <= {TAG_W{1'b0}};
            rdy_q <= 1'b0;
        end else begin
            val_q <= val_d;
            tag_q <= tag_d;
            rdy_q <= rdy_d;
        end
    end

    assign val      = val_q;
    assign rdy_next = rdy_d;

endmodule

// File: rtl/rs_entry_8bit.sv
// Single reservation-station entry: EMPTY -> WAIT (operands pending) -> READY (offered for issue).
module rs_entry_8bit
    import rs_entry_8bit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    rs_entry_8bit_if.slave bus
);

    rs_state_e         state_q, state_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              use_imm_q, use_imm_d;
    logic              issue_valid_q, issue_valid_d;
    logic              alloc_take;
    logic              watch;
    logic              b_alloc_rdy;
    logic              a_rdy_next, b_rdy_next;
    logic [DATA_W-1:0] a_val, b_val;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; flush overrides everything below reset.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (bus.alloc_valid) begin
                        state_d = (a_rdy_next && b_rdy_next) ? ST_READY : ST_WAIT;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_WAIT: begin
                    if (a_rdy_next && b_rdy_next) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_READY: begin
                    if (bus.issue_ready) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Datapath controls; an immediate-form instruction treats B as already satisfied.
    always_comb begin
        alloc_take    = (state_q == ST_EMPTY) && bus.alloc_valid && !bus.flush;
        watch         = (state_q == ST_WAIT) && !bus.flush;
        b_alloc_rdy   = bus.alloc_b_rdy | bus.alloc_use_imm;
        issue_valid_d = (state_d == ST_READY);
        if (alloc_take) begin
            imm_d     = bus.alloc_imm;
            use_imm_d = bus.alloc_use_imm;
        end else begin
            imm_d     = imm_q;
            use_imm_d = use_imm_q;
        end
    end

    // Immediate and issue-valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imm_q         <= {DATA_W{1'b0}};
            use_imm_q     <= 1'b0;
            issue_valid_q <= 1'b0;
        end else begin
            imm_q         <= imm_d;
            use_imm_q     <= use_imm_d;
            issue_valid_q <= issue_valid_d;
        end
    end

    operand_slot_8bit u_slot_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (alloc_take),
        .alloc_rdy (bus.alloc_a_rdy),
        .alloc_tag (bus.alloc_a_tag),
        .alloc_val (bus.alloc_a_val),
        .watch     (watch),
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .cdb_data  (bus.cdb_data),
        .val       (a_val),
        .rdy_next  (a_rdy_next)
    );

    operand_slot_8bit u_slot_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (alloc_take),
        .alloc_rdy (b_alloc_rdy),
        .alloc_tag (bus.alloc_b_tag),
        .alloc_val (bus.alloc_b_val),
        .watch     (watch),
        .cdb_valid (bus.cdb_valid),
        .cdb_tag   (bus.cdb_tag),
        .cdb_data  (bus.cdb_data),
        .val       (b_val),
        .rdy_next  (b_rdy_next)
    );

    assign bus.alloc_ready   = (state_q == ST_EMPTY);
    assign bus.issue_valid   = issue_valid_q;
    assign bus.issue_a       = a_val;
    assign bus.issue_b       = b_val;
    assign bus.issue_imm     = imm_q;
    assign bus.issue_use_imm = use_imm_q;

endmodule
